// File: rtl/priority_irq_ctrl.sv
// priority_irq_ctrl: registered N-line priority interrupt controller with valid/ack handshake (rotating priority when PRIO_ROUND_ROBIN_EN is defined)
module priority_irq_ctrl #(
  parameter int N = 8,
  parameter bit EDGE = 1'b1,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  input  logic             irq_ack,
  output logic             any_pending
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_n;
  logic [N-1:0] pending, req_d, set, clr, cand;
  logic [IDX_W-1:0] winner;
  logic take;
`ifdef PRIO_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;
`endif
  assign irq_valid = state == PRESENT;
  assign any_pending = |pending;
  assign take = irq_valid && irq_ack;
  assign set = EDGE ? (req & ~req_d) : req;
  assign clr = take ? (N'(1) << irq_idx) : '0;
  assign cand = pending & mask;
  // winner: highest index in fixed mode, first hit searching down from ptr in rotating mode
  always_comb begin
    winner = '0;
`ifdef PRIO_ROUND_ROBIN_EN
    for (int o = N - 1; o >= 0; o--)
      if (cand[(int'(ptr) + N - o) % N]) winner = IDX_W'((int'(ptr) + N - o) % N);
`else
    for (int i = 0; i < N; i++)
      if (cand[i]) winner = IDX_W'(i);
`endif
  end
  // next state: grant from IDLE when any candidate exists, hold the grant until acked
  always_comb begin
    state_n = state == IDLE ? (|cand ? PRESENT : IDLE) : (irq_ack ? IDLE : PRESENT);
  end
  // state, capture and pending registers; set beats clear on the same bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pending <= '0;
      req_d <= '0;
      irq_idx <= '0;
    end else begin
      state <= state_n;
      req_d <= req;
      pending <= (pending & ~clr) | set;
      if (state == IDLE && |cand) irq_idx <= winner;
    end
  end
`ifdef PRIO_ROUND_ROBIN_EN
  // rotate priority so the line just serviced becomes lowest
  always_ff @(posedge clk) begin
    if (rst) ptr <= IDX_W'(N - 1);
    else if (take) ptr <= irq_idx == '0 ? IDX_W'(N - 1) : irq_idx - 1'b1;
  end
`endif
endmodule
